sdsp_update_unit: RTL

Consumer side of the neuron calcium variable: reads the calcium and membrane state the neuron update logic writes back, and applies spike-driven synaptic plasticity (SDSP) with calcium stop-learning to one 32-bit synaptic word (8 synapses) per transaction. Sits between the pre-synaptic event scheduler (word source), the neuron state memory (read port), and the synapse memory write-back path (word sink).

---
 rtl/sdsp_update_unit.sv | 119 +++++++++++
 1 files changed

// File: rtl/sdsp_update_unit.sv
// SDSP synaptic word updater: fetches post-neuron state for 8 synapses and applies saturating up/down.
// Optional calcium stop-learning windows enabled by defining SDSP_CALCIUM_GATE_EN.
module sdsp_update_unit (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  input  logic [4:0]  in_group,
  output logic        neur_rd_en,
  output logic [7:0]  neur_addr,
  input  logic [2:0]  neur_rd_calcium,
  input  logic [7:0]  neur_rd_vmem,
  input  logic [7:0]  param_thr_mem,
  input  logic [2:0]  param_ca_thr1,
  input  logic [2:0]  param_ca_thr2,
  input  logic [2:0]  param_ca_thr3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [4:0]  out_group
);
  typedef enum logic [1:0] {IDLE, FETCH, FINAL, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx, pidx;
  logic        proc_vld;
  logic [31:0] word_q;
  logic [4:0]  grp_q;
  logic [7:0]  thr_mem_q;
  logic        accept;
  logic [3:0]  syn, syn_nxt;
  logic        v_ge, up, down;

  assign accept = in_valid & in_ready;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = FETCH;
      FETCH: if (idx == 3'd7) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    neur_rd_en = (state == FETCH);
    out_valid  = (state == DONE);
    neur_addr  = (state == FETCH) ? {grp_q, idx} : 8'd0;
  end

  // Synapse pidx consumes the read data returned for the strobe of the previous cycle
  assign syn  = word_q[pidx*4 +: 4];
  assign v_ge = (neur_rd_vmem >= thr_mem_q);

`ifdef SDSP_CALCIUM_GATE_EN
  logic [2:0] ca1_q, ca2_q, ca3_q;
  logic       ca_up_win, ca_dn_win;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ca1_q <= '0;
      ca2_q <= '0;
      ca3_q <= '0;
    end else if (accept) begin
      ca1_q <= param_ca_thr1;
      ca2_q <= param_ca_thr2;
      ca3_q <= param_ca_thr3;
    end

  assign ca_up_win = (neur_rd_calcium >= ca1_q) && (neur_rd_calcium < ca3_q);
  assign ca_dn_win = (neur_rd_calcium >= ca1_q) && (neur_rd_calcium < ca2_q);
  assign up   = syn[3] &  v_ge & ca_up_win;
  assign down = syn[3] & ~v_ge & ca_dn_win;
`else
  logic unused_ca;
  assign unused_ca = ^{neur_rd_calcium, param_ca_thr1, param_ca_thr2, param_ca_thr3};
  assign up   = syn[3] &  v_ge;
  assign down = syn[3] & ~v_ge;
`endif

  always_comb begin
    syn_nxt = syn;
    if (up && syn[2:0] != 3'd7)        syn_nxt[2:0] = syn[2:0] + 3'd1;
    else if (down && syn[2:0] != 3'd0) syn_nxt[2:0] = syn[2:0] - 3'd1;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      idx       <= '0;
      pidx      <= '0;
      proc_vld  <= 1'b0;
      word_q    <= '0;
      grp_q     <= '0;
      thr_mem_q <= '0;
    end else begin
      proc_vld <= (state == FETCH);
      pidx     <= idx;
      if (accept) begin
        word_q    <= in_word;
        grp_q     <= in_group;
        thr_mem_q <= param_thr_mem;
        idx       <= '0;
      end else begin
        if (state == FETCH) idx <= idx + 3'd1;
        if (proc_vld)       word_q[pidx*4 +: 4] <= syn_nxt;
      end
    end

  assign out_word  = word_q;
  assign out_group = grp_q;
endmodule
